// File: rtl/cprv_ex_stage.sv
// Execute stage of the cprv64g in-order pipeline: RV64I integer ALU / address
// generation feeding a single-entry pipeline register towards MEM.
module cprv_ex_stage #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_ex_i,
    output logic                  ready_ex_o,
    input  logic [DATA_WIDTH-1:0] rs1_data_ex_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_ex_i,
    input  logic [4:0]            rd_addr_ex_i,
    input  logic                  rd_en_ex_i,
    input  logic [DATA_WIDTH-1:0] imm_data_ex_i,
    input  logic [6:0]            opcode_ex_i,
    input  logic [2:0]            funct3_ex_i,
    input  logic [6:0]            funct7_ex_i,
    output logic                  valid_mem_o,
    input  logic                  ready_mem_i,
    output logic [DATA_WIDTH-1:0] alu_result_mem_o,
    output logic [DATA_WIDTH-1:0] rs2_data_mem_o,
    output logic [4:0]            rd_addr_mem_o,
    output logic                  rd_en_mem_o,
    output logic                  mem_r_en_mem_o,
    output logic                  mem_w_en_mem_o,
    output logic [2:0]            funct3_mem_o
);

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_alu_result;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [4:0]            r_rd_addr;
    logic                  r_rd_en;
    logic                  r_mem_r_en;
    logic                  r_mem_w_en;
    logic [2:0]            r_funct3;

    logic                  w_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic [5:0]            w_shamt64;
    logic [4:0]            w_shamt32;
    logic [31:0]           w_a32;
    logic [31:0]           w_b32;
    logic [DATA_WIDTH-1:0] w_res64;
    logic [31:0]           w_res32;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_known_op;
    logic                  w_rd_en;
    logic                  w_unused;

    // Only funct7[5] (SUB/SRA select) carries meaning for RV64I.
    assign w_unused = &{1'b0, funct7_ex_i[6], funct7_ex_i[4:0]};

    assign w_ready  = ~r_valid | ready_mem_i;
    assign w_accept = valid_ex_i & w_ready;

    assign w_op_b    = ((opcode_ex_i == OPC_OP) || (opcode_ex_i == OPC_OP_32)) ? rs2_data_ex_i
                                                                              : imm_data_ex_i;
    assign w_shamt64 = w_op_b[5:0];
    assign w_shamt32 = w_op_b[4:0];
    assign w_a32     = rs1_data_ex_i[31:0];
    assign w_b32     = w_op_b[31:0];

    always_comb begin
        w_res64 = '0;
        case (funct3_ex_i)
            3'b000: w_res64 = ((opcode_ex_i == OPC_OP) && funct7_ex_i[5])
                              ? rs1_data_ex_i - w_op_b : rs1_data_ex_i + w_op_b;
            3'b001: w_res64 = rs1_data_ex_i << w_shamt64;
            3'b010: w_res64 = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_data_ex_i) < $signed(w_op_b))};
            3'b011: w_res64 = {{(DATA_WIDTH-1){1'b0}}, (rs1_data_ex_i < w_op_b)};
            3'b100: w_res64 = rs1_data_ex_i ^ w_op_b;
            3'b101: w_res64 = funct7_ex_i[5] ? DATA_WIDTH'($signed(rs1_data_ex_i) >>> w_shamt64)
                                             : rs1_data_ex_i >> w_shamt64;
            3'b110: w_res64 = rs1_data_ex_i | w_op_b;
            default: w_res64 = rs1_data_ex_i & w_op_b;
        endcase
    end

    always_comb begin
        w_res32 = '0;
        case (funct3_ex_i)
            3'b000: w_res32 = ((opcode_ex_i == OPC_OP_32) && funct7_ex_i[5])
                              ? w_a32 - w_b32 : w_a32 + w_b32;
            3'b001: w_res32 = w_a32 << w_shamt32;
            3'b101: w_res32 = funct7_ex_i[5] ? 32'($signed(w_a32) >>> w_shamt32)
                                             : w_a32 >> w_shamt32;
            default: w_res32 = '0;
        endcase
    end

    always_comb begin
        w_result   = '0;
        w_known_op = 1'b1;
        case (opcode_ex_i)
            OPC_OP, OPC_OP_IMM:       w_result = w_res64;
            OPC_OP_32, OPC_OP_IMM_32: w_result = {{(DATA_WIDTH-32){w_res32[31]}}, w_res32};
            OPC_LOAD, OPC_STORE:      w_result = rs1_data_ex_i + imm_data_ex_i;
            default:                  w_known_op = 1'b0;
        endcase
    end

    // x0 is hardwired to zero, so a write to it is squashed here.
    assign w_rd_en = rd_en_ex_i & (rd_addr_ex_i != 5'd0) & w_known_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_rs2_data   <= '0;
            r_rd_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_mem_w_en   <= 1'b0;
            r_funct3     <= '0;
        end else if (w_ready) begin
            r_valid <= valid_ex_i;
            if (w_accept) begin
                r_alu_result <= w_result;
                r_rs2_data   <= rs2_data_ex_i;
                r_rd_addr    <= rd_addr_ex_i;
                r_rd_en      <= w_rd_en;
                r_mem_r_en   <= (opcode_ex_i == OPC_LOAD);
                r_mem_w_en   <= (opcode_ex_i == OPC_STORE);
                r_funct3     <= funct3_ex_i;
            end
        end
    end

    assign ready_ex_o       = w_ready;
    assign valid_mem_o      = r_valid;
    assign alu_result_mem_o = r_alu_result;
    assign rs2_data_mem_o   = r_rs2_data;
    assign rd_addr_mem_o    = r_rd_addr;
    assign rd_en_mem_o      = r_rd_en;
    assign mem_r_en_mem_o   = r_mem_r_en;
    assign mem_w_en_mem_o   = r_mem_w_en;
    assign funct3_mem_o     = r_funct3;

endmodule

// File: tb/tb_cprv_ex_stage.sv
// Directed vector table, backpressure/reset sequences and a random stream
// checked against an independent reference ALU for cprv_ex_stage.
module tb_cprv_ex_stage;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] OP32  = 7'b0111011;
    localparam logic [6:0] OPI32 = 7'b0011011;
    localparam logic [6:0] LD    = 7'b0000011;
    localparam logic [6:0] ST    = 7'b0100011;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ex_i;
    logic        ready_ex_o;
    logic [63:0] rs1_data_ex_i;
    logic [63:0] rs2_data_ex_i;
    logic [4:0]  rd_addr_ex_i;
    logic        rd_en_ex_i;
    logic [63:0] imm_data_ex_i;
    logic [6:0]  opcode_ex_i;
    logic [2:0]  funct3_ex_i;
    logic [6:0]  funct7_ex_i;
    logic        valid_mem_o;
    logic        ready_mem_i;
    logic [63:0] alu_result_mem_o;
    logic [63:0] rs2_data_mem_o;
    logic [4:0]  rd_addr_mem_o;
    logic        rd_en_mem_o;
    logic        mem_r_en_mem_o;
    logic        mem_w_en_mem_o;
    logic [2:0]  funct3_mem_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cprv_ex_stage #(.DATA_WIDTH(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_ex_i       (valid_ex_i),
        .ready_ex_o       (ready_ex_o),
        .rs1_data_ex_i    (rs1_data_ex_i),
        .rs2_data_ex_i    (rs2_data_ex_i),
        .rd_addr_ex_i     (rd_addr_ex_i),
        .rd_en_ex_i       (rd_en_ex_i),
        .imm_data_ex_i    (imm_data_ex_i),
        .opcode_ex_i      (opcode_ex_i),
        .funct3_ex_i      (funct3_ex_i),
        .funct7_ex_i      (funct7_ex_i),
        .valid_mem_o      (valid_mem_o),
        .ready_mem_i      (ready_mem_i),
        .alu_result_mem_o (alu_result_mem_o),
        .rs2_data_mem_o   (rs2_data_mem_o),
        .rd_addr_mem_o    (rd_addr_mem_o),
        .rd_en_mem_o      (rd_en_mem_o),
        .mem_r_en_mem_o   (mem_r_en_mem_o),
        .mem_w_en_mem_o   (mem_w_en_mem_o),
        .funct3_mem_o     (funct3_mem_o)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rd_en;
        logic [63:0] exp_res;
        logic        exp_rd_en;
        logic        exp_r;
        logic        exp_w;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    // Results handed to MEM, captured at each output handshake.
    logic [63:0] sb_q[$];
    always @(posedge clk) begin
        if (rst_n === 1'b1 && valid_mem_o === 1'b1 && ready_mem_i === 1'b1)
            sb_q.push_back(alu_result_mem_o);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                                input logic [4:0] rd, input logic rd_en, input logic [63:0] res,
                                input logic erd, input logic er, input logic ew);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.rd = rd; v.rd_en = rd_en; v.exp_res = res; v.exp_rd_en = erd; v.exp_r = er; v.exp_w = ew;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                         input logic [4:0] rd, input logic rd_en);
        valid_ex_i = v; opcode_ex_i = op; funct3_ex_i = f3; funct7_ex_i = f7;
        rs1_data_ex_i = rs1; rs2_data_ex_i = rs2; imm_data_ex_i = imm;
        rd_addr_ex_i = rd; rd_en_ex_i = rd_en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sra64(input logic [63:0] a, input int sh);
        logic [63:0] ones = '1;
        return (a >> sh) | (a[63] ? ~(ones >> sh) : 64'd0);
    endfunction

    function automatic logic [31:0] sra32(input logic [31:0] a, input int sh);
        logic [31:0] ones = '1;
        return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
    endfunction

    function automatic logic [63:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [63:0] a, input logic [63:0] rs2, input logic [63:0] imm);
        logic [63:0] b;
        logic [31:0] w;
        int sh;
        b = (op == OP || op == OP32) ? rs2 : imm;
        if (op == LD || op == ST) return a + imm;
        if (op == OP || op == OPI) begin
            sh = int'(b[5:0]);
            case (f3)
                3'd0: return (op == OP && f7[5]) ? a + ~b + 64'd1 : a + b;
                3'd1: return a << sh;
                3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                3'd3: return (a < b) ? 64'd1 : 64'd0;
                3'd4: return a ^ b;
                3'd5: return f7[5] ? sra64(a, sh) : a >> sh;
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        if (op == OP32 || op == OPI32) begin
            sh = int'(b[4:0]);
            case (f3)
                3'd0: w = (op == OP32 && f7[5]) ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
                3'd1: w = a[31:0] << sh;
                3'd5: w = f7[5] ? sra32(a[31:0], sh) : a[31:0] >> sh;
                default: return 64'd0;
            endcase
            return {{32{w[31]}}, w};
        end
        return 64'd0;
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        return op == OP || op == OPI || op == OP32 || op == OPI32 || op == LD || op == ST;
    endfunction

    initial begin
        logic [6:0]  ops[7];
        logic [6:0]  r_op;
        logic [2:0]  r_f3;
        logic [6:0]  r_f7;
        logic [63:0] r_rs1, r_rs2, r_imm;
        logic [11:0] r_imm12;
        logic [4:0]  r_rd;
        logic        r_rden, r_v;
        logic        m_valid, m_rd_en, m_r, m_w, m_ready;
        logic [63:0] m_res, m_rs2;
        logic [4:0]  m_rd;
        logic [2:0]  m_f3;
        int accepted, cyc;

        vecs[0]  = mk(OP,   3'd0, 7'h00, 64'd5, 64'd7, 64'd0, 5'd3, 1'b1, 64'd12, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(OP,   3'd0, 7'h20, 64'd5, 64'd7, 64'd0, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(OP32, 3'd0, 7'h00, 64'h7FFF_FFFF, 64'd1, 64'd0, 5'd4, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(OPI,  3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(OP,   3'd3, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd6, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(OP,   3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd6, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(LD,   3'd3, 7'h00, 64'h1000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd7, 1'b1, 64'h0FF8, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(ST,   3'd2, 7'h00, 64'h2000, 64'hAB, 64'h10, 5'd0, 1'b0, 64'h2010, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(OPI,  3'd0, 7'h00, 64'd1, 64'd0, 64'd2, 5'd0, 1'b1, 64'd3, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(BAD,  3'd0, 7'h00, 64'd9, 64'd9, 64'd9, 5'd5, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(OP32, 3'd0, 7'h20, 64'd0, 64'd1, 64'd0, 5'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(OPI,  3'd0, 7'h20, 64'd5, 64'd0, 64'd7, 5'd9, 1'b1, 64'd12, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(OP32, 3'd5, 7'h20, 64'h8000_0000, 64'd4, 64'd0, 5'd10, 1'b1, 64'hFFFF_FFFF_F800_0000, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(OP32, 3'd5, 7'h00, 64'h8000_0000, 64'd4, 64'd0, 5'd10, 1'b1, 64'h0800_0000, 1'b1, 1'b0, 1'b0);
        vecs[14] = mk(OPI32,3'd1, 7'h00, 64'd1, 64'd0, 64'd31, 5'd11, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(OP32, 3'd4, 7'h00, 64'd3, 64'd5, 64'd0, 5'd12, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(OP,   3'd1, 7'h00, 64'd1, 64'h40, 64'd0, 5'd13, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
        vecs[17] = mk(OP,   3'd5, 7'h00, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 5'd14, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
        vecs[18] = mk(OPI,  3'd4, 7'h00, 64'hF0, 64'd0, 64'hFF, 5'd15, 1'b1, 64'h0F, 1'b1, 1'b0, 1'b0);
        vecs[19] = mk(OPI,  3'd6, 7'h00, 64'hF0, 64'd0, 64'hFF, 5'd16, 1'b1, 64'hFF, 1'b1, 1'b0, 1'b0);
        vecs[20] = mk(OPI,  3'd7, 7'h00, 64'hF0, 64'd0, 64'hFF, 5'd17, 1'b1, 64'hF0, 1'b1, 1'b0, 1'b0);

        // Reset state
        rst_n = 1'b0;
        ready_mem_i = 1'b1;
        drive(1'b0, 7'd0, 3'd0, 7'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_valid", 64'(valid_mem_o), 64'd0);
        chk("reset_ready", 64'(ready_ex_o), 64'd1);
        chk("reset_result", alu_result_mem_o, 64'd0);
        chk("reset_enables", {61'd0, rd_en_mem_o, mem_r_en_mem_o, mem_w_en_mem_o}, 64'd0);

        // Directed vectors back to back: one per cycle
        ready_mem_i = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                  vecs[i].rd, vecs[i].rd_en);
            chk($sformatf("vec%0d_ready", i), 64'(ready_ex_o), 64'd1);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(valid_mem_o), 64'd1);
            chk($sformatf("vec%0d_result", i), alu_result_mem_o, vecs[i].exp_res);
            chk($sformatf("vec%0d_rs2", i), rs2_data_mem_o, vecs[i].rs2);
            chk($sformatf("vec%0d_rd", i), 64'(rd_addr_mem_o), 64'(vecs[i].rd));
            chk($sformatf("vec%0d_f3", i), 64'(funct3_mem_o), 64'(vecs[i].f3));
            chk($sformatf("vec%0d_en", i), {61'd0, rd_en_mem_o, mem_r_en_mem_o, mem_w_en_mem_o},
                {61'd0, vecs[i].exp_rd_en, vecs[i].exp_r, vecs[i].exp_w});
            $display("vec %0d op=%b f3=%0d result=%h", i, vecs[i].op, vecs[i].f3, alu_result_mem_o);
        end
        valid_ex_i = 1'b0;
        tick();
        chk("bubble_valid", 64'(valid_mem_o), 64'd0);

        // Backpressure: A stalls for 3 cycles while B waits, then drain and fill in one edge
        sb_q.delete();
        drive(1'b1, OP, 3'd0, 7'h00, 64'd1, 64'd2, 64'd0, 5'd4, 1'b1);
        tick();
        ready_mem_i = 1'b0;
        drive(1'b1, OP, 3'd0, 7'h00, 64'd10, 64'd20, 64'd0, 5'd6, 1'b1);
        #1;
        chk("stall_ready0", 64'(ready_ex_o), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_valid", c), 64'(valid_mem_o), 64'd1);
            chk($sformatf("stall%0d_result", c), alu_result_mem_o, 64'd3);
            chk($sformatf("stall%0d_rd", c), 64'(rd_addr_mem_o), 64'd4);
            chk($sformatf("stall%0d_ready", c), 64'(ready_ex_o), 64'd0);
            $display("stall cycle %0d result=%h ready=%0b", c, alu_result_mem_o, ready_ex_o);
        end
        ready_mem_i = 1'b1;
        #1;
        chk("release_ready", 64'(ready_ex_o), 64'd1);
        tick();
        chk("fill_valid", 64'(valid_mem_o), 64'd1);
        chk("fill_result", alu_result_mem_o, 64'd30);
        chk("fill_rd", 64'(rd_addr_mem_o), 64'd6);
        valid_ex_i = 1'b0;
        tick();
        chk("drain_valid", 64'(valid_mem_o), 64'd0);
        chk("sb_count", 64'(sb_q.size()), 64'd2);
        if (sb_q.size() == 2) begin
            chk("sb_first", sb_q[0], 64'd3);
            chk("sb_second", sb_q[1], 64'd30);
        end
        $display("backpressure handoffs=%0d", sb_q.size());

        // Reset while stalled
        drive(1'b1, LD, 3'd3, 7'h00, 64'h100, 64'h55, 64'h8, 5'd7, 1'b1);
        tick();
        ready_mem_i = 1'b0;
        valid_ex_i = 1'b0;
        tick();
        chk("prereset_valid", 64'(valid_mem_o), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_valid", 64'(valid_mem_o), 64'd0);
        chk("rst_ready", 64'(ready_ex_o), 64'd1);
        chk("rst_result", alu_result_mem_o, 64'd0);
        chk("rst_rs2", rs2_data_mem_o, 64'd0);
        chk("rst_rd_f3", {56'd0, rd_addr_mem_o, funct3_mem_o}, 64'd0);
        chk("rst_enables", {61'd0, rd_en_mem_o, mem_r_en_mem_o, mem_w_en_mem_o}, 64'd0);
        $display("reset during stall valid=%0b ready=%0b", valid_mem_o, ready_ex_o);
        rst_n = 1'b1;
        ready_mem_i = 1'b1;

        // Random stream against the reference model
        ops[0] = OP; ops[1] = OPI; ops[2] = OP32; ops[3] = OPI32; ops[4] = LD; ops[5] = ST; ops[6] = BAD;
        m_valid = 1'b0; m_res = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_rd_en = 1'b0; m_r = 1'b0; m_w = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            r_op    = ops[$urandom_range(6, 0)];
            r_f3    = 3'($urandom_range(7, 0));
            r_f7    = ($urandom_range(1, 0) == 1) ? 7'h20 : 7'h00;
            r_rs1   = {$urandom, $urandom};
            r_rs2   = ($urandom_range(3, 0) == 0) ? 64'($urandom_range(70, 0)) : {$urandom, $urandom};
            r_imm12 = 12'($urandom);
            r_imm   = {{52{r_imm12[11]}}, r_imm12};
            r_rd    = 5'($urandom_range(31, 0));
            r_rden  = 1'($urandom_range(1, 0));
            r_v     = ($urandom_range(3, 0) != 0);
            ready_mem_i = ($urandom_range(3, 0) != 0);
            drive(r_v, r_op, r_f3, r_f7, r_rs1, r_rs2, r_imm, r_rd, r_rden);
            #1;
            m_ready = !m_valid || ready_mem_i;
            chk("rand_ready", 64'(ready_ex_o), 64'(m_ready));
            @(posedge clk);
            if (m_ready) begin
                m_valid = r_v;
                if (r_v) begin
                    accepted++;
                    m_res   = ref_alu(r_op, r_f3, r_f7, r_rs1, r_rs2, r_imm);
                    m_rs2   = r_rs2;
                    m_rd    = r_rd;
                    m_f3    = r_f3;
                    m_rd_en = known_op(r_op) && r_rden && (r_rd != 5'd0);
                    m_r     = (r_op == LD);
                    m_w     = (r_op == ST);
                end
            end
            #1;
            cyc++;
            chk("rand_valid", 64'(valid_mem_o), 64'(m_valid));
            if (m_valid) begin
                chk("rand_result", alu_result_mem_o, m_res);
                chk("rand_fields", {rs2_data_mem_o ^ {51'd0, m_rd, m_f3, m_rd_en, m_r, m_w}},
                    {m_rs2 ^ {51'd0, rd_addr_mem_o, funct3_mem_o, rd_en_mem_o, mem_r_en_mem_o, mem_w_en_mem_o}});
            end
        end
        chk("rand_accept_count", 64'(accepted), 64'd1000);
        $display("random stream accepted=%0d cycles=%0d", accepted, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cprv_ex_stage.md
# cprv_ex_stage

Execute stage of the cprv64g in-order pipeline. It accepts decoded instructions from the ID stage over a valid/ready handshake and computes the RV64I integer ALU result, or the effective address for LOAD/STORE. The result is registered into a single-entry pipeline register, which it presents to the MEM stage over a second valid/ready handshake. It is the receiving end of the ID stage's `*_ex_*` interface.

## Interface
- DATA_WIDTH, 64, datapath width; only 64 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- valid_ex_i  in  1  ID presents an instruction.
- ready_ex_o  out  1  EX accepts this cycle.
- rs1_data_ex_i  in  64  rs1 operand.
- rs2_data_ex_i  in  64  rs2 operand, also store data.
- rd_addr_ex_i  in  5  destination register.
- rd_en_ex_i  in  1  instruction writes rd.
- imm_data_ex_i  in  64  immediate, already sign-extended by ID.
- opcode_ex_i  in  7  instr[6:0].
- funct3_ex_i  in  3  instr[14:12].
- funct7_ex_i  in  7  instr[31:25].
- valid_mem_o  out  1  EX register holds an instruction for MEM.
- ready_mem_i  in  1  MEM accepts this cycle.
- alu_result_mem_o  out  64  ALU result or effective address.
- rs2_data_mem_o  out  64  store data.
- rd_addr_mem_o  out  5  destination register.
- rd_en_mem_o  out  1  writeback enable.
- mem_r_en_mem_o  out  1  LOAD.
- mem_w_en_mem_o  out  1  STORE.
- funct3_mem_o  out  3  access size and sign for MEM.

## Operation
- Opcodes:
  - OP=0110011
  - OP_IMM=0010011
  - OP_32=0111011
  - OP_IMM_32=0011011
  - LOAD=0000011
  - STORE=0100011
- Operand B selection:
  - OP and OP_32 use rs2_data.
  - All other opcodes use imm_data.
- funct3 decode, 64-bit:
  - 000: ADD, or SUB only when opcode is OP and funct7[5]=1. OP_IMM never subtracts.
  - 001: SLL.
  - 010: SLT, signed compare; result 1 or 0.
  - 011: SLTU, unsigned compare; result 1 or 0.
  - 100: XOR.
  - 101: SRL when funct7[5]=0, SRA when funct7[5]=1.
  - 110: OR.
  - 111: AND.
- 64-bit shift amount is B[5:0].
- *_32 variants:
  - Supported funct3: 000, 001, 101, with 000 covering ADDW, SUBW and ADDIW.
  - Operate on A[31:0] and B[31:0]; shift amount is B[4:0].
  - The 32-bit result is sign-extended from bit 31.
  - SRAW and SRAIW shift sign-extended bit 31.
  - Any other funct3 with a *_32 opcode gives result 0.
- LOAD and STORE:
  - Result = rs1 + imm, modulo 2^64.
  - mem_r_en is set for LOAD, mem_w_en for STORE.
- Unknown opcode:
  - The instruction still propagates with valid.
  - Result = 0; rd_en, mem_r_en and mem_w_en = 0.
- rd_en_mem_o is registered as rd_en_ex_i & (rd_addr_ex_i != 0), so x0 is never written.
- All arithmetic wraps; no overflow detection; no exceptions.

## Timing
- ready_ex_o = ~valid_mem_o | ready_mem_i. This is combinational; it does not depend on valid_ex_i.
- Transfer in: valid_ex_i & ready_ex_o at a rising edge.
  - On transfer, all *_mem_o registers load the new instruction.
  - valid_mem_o <= 1.
- When ready_ex_o=1 and valid_ex_i=0:
  - valid_mem_o <= 0.
  - Data registers are don't-care but must not be X.
- When ready_ex_o=0, every output holds. Stall: valid_mem_o=1 and ready_mem_i=0.
- Latency: 1 cycle from accept to valid_mem_o.
- Throughput: 1 instruction per cycle while ready_mem_i=1.
- Simultaneous drain and fill: valid_mem_o=1, ready_mem_i=1 and valid_ex_i=1.
  - The old entry leaves and the new one loads in the same edge.
  - valid_mem_o stays 1.
- MEM must treat the outputs as stable while valid_mem_o=1 and ready_mem_i=0.
- Reset (rst_n=0 at an edge) overrides everything, including an in-flight stall.
  - valid_mem_o=0.
  - alu_result, rs2_data, rd_addr, funct3 = 0.
  - rd_en, mem_r_en, mem_w_en = 0.
  - ready_ex_o=1 in the cycle after reset.
  - An instruction held at reset is dropped.

## Test plan
- ADD and SUB: OP, funct3=000.
  - funct7=0000000, rs1=5, rs2=7 -> result 12.
  - funct7=0100000 -> result 0xFFFF_FFFF_FFFF_FFFE.
  - Both with valid_mem_o=1 one cycle after accept and rd_en=1 for rd=3.
- Word ops and shifts:
  - ADDW with rs1=0x7FFF_FFFF, rs2=1 -> 0xFFFF_FFFF_8000_0000.
  - SRAI with rs1=0x8000_0000_0000_0000, imm=63, funct7=0100000 -> all ones.
  - SLTU with rs1=-1, rs2=1 -> 0.
- Memory ops:
  - LOAD with rs1=0x1000, imm=-8 -> result 0x0FF8, mem_r_en=1, mem_w_en=0.
  - STORE with rs2=0xAB -> mem_w_en=1, rs2_data_mem_o=0xAB, rd_en=0.
- Backpressure:
  - Hold ready_mem_i=0 for 3 cycles with valid_mem_o=1 -> outputs are constant and ready_ex_o=0.
  - Release with valid_ex_i=1 -> the old entry drains and the new one appears on the next edge.
  - Check with a scoreboard that nothing is lost or duplicated.
- Edge cases:
  - rd_addr=0 with rd_en=1 -> rd_en_mem_o=0.
  - opcode=1111111 -> valid propagates, result 0, all enables 0.
- Reset:
  - Assert rst_n=0 during a stall -> next cycle valid_mem_o=0, all outputs 0 and ready_ex_o=1.
  - Random stream of 1000 instructions against a reference ALU model.
